// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction fetch unit.
// Optional feature macro: MIPS_FETCH_PERF_CNT_EN (see mips_fetch_unit).
package mips_fetch_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;
  localparam int FIELD_W = 6;

  // Sequential fetch advances one 32-bit word.
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  // Instruction field bit ranges.
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int JT_HI  = 25;
  localparam int JT_LO  = 0;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_t;

  // Branch displacement: sign-extended word offset converted to a byte offset.
  function automatic logic [ADDR_W-1:0] branch_offset(input logic [IMM_HI:IMM_LO] imm);
    return {{(ADDR_W - 18){imm[IMM_HI]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Fetch unit bus: instruction memory request/response, the instruction
// handed to decode, and the redirect controls returned from decode/control.
interface mips_fetch_unit_if;
  import mips_fetch_pkg::*;

  // Instruction memory side.
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_valid;

  // Decode side.
  logic [INSTR_W-1:0] instr;
  logic [FIELD_W-1:0] op_code;
  logic [FIELD_W-1:0] function_code;
  logic               instr_valid;
  logic [ADDR_W-1:0]  pc;
  logic               decode_ready;
  logic               is_branch;
  logic               branch_taken;
  logic               is_jump;

  // The fetch unit drives requests and the held instruction.
  modport master (
    output imem_req, imem_addr, instr, op_code, function_code, instr_valid, pc,
    input  imem_rdata, imem_valid, decode_ready, is_branch, branch_taken, is_jump
  );

  // Memory and decode/control on the far side of the bus.
  modport slave (
    input  imem_req, imem_addr, instr, op_code, function_code, instr_valid, pc,
    output imem_rdata, imem_valid, decode_ready, is_branch, branch_taken, is_jump
  );

endinterface

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: jump, then taken branch, then pc+4.
// All arithmetic wraps modulo 2^32.
module fetch_next_pc
  import mips_fetch_pkg::*;
(
  input  logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               is_jump,
  input  logic               is_branch,
  input  logic               branch_taken,
  output logic [ADDR_W-1:0]  next_pc
);

  logic [ADDR_W-1:0] pc4;

  // The opcode field plays no part in target arithmetic; control logic
  // has already classified the instruction through is_jump/is_branch.
  logic unused_opcode;
  assign unused_opcode = ^instr[OP_HI:OP_LO];

  assign pc4 = pc + PC_STEP;

  // Redirect priority: a jump wins even when is_branch is also high.
  always_comb begin
    // NOTE: assign a default before any branch so every path drives
    // next_pc; an uncovered path would infer a latch.
    next_pc = pc4;
    if (is_jump) begin
      next_pc = {pc4[ADDR_W-1:ADDR_W-4], instr[JT_HI:JT_LO], 2'b00};
    end else if (is_branch && branch_taken) begin
      next_pc = pc4 + branch_offset(instr[IMM_HI:IMM_LO]);
    end
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// MIPS instruction fetch sequencer: holds the PC, issues one outstanding
// instruction memory request at a time, and hands the fetched word to
// decode under a valid/ready handshake. Decode's accept cycle redirects
// the PC via fetch_next_pc.
// Optional feature macro: MIPS_FETCH_PERF_CNT_EN adds retired_count and
// stall_count performance counter outputs.
module mips_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int unsigned       PC_WIDTH = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  mips_fetch_unit_if.master bus
`ifdef MIPS_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       retired_count,
  output logic [31:0]       stall_count
`endif
);

  state_t               state_q;
  state_t               state_d;
  logic [PC_WIDTH-1:0]  pc_q;
  logic [INSTR_W-1:0]   instr_q;
  logic                 instr_valid_q;
  logic [PC_WIDTH-1:0]  next_pc;
  logic                 accept;
  logic                 capture;

  // Downstream takes the held instruction this cycle.
  assign accept = instr_valid_q & bus.decode_ready;

  fetch_next_pc u_next_pc (
    .pc           (pc_q),
    .instr        (instr_q),
    .is_jump      (bus.is_jump),
    .is_branch    (bus.is_branch),
    .branch_taken (bus.branch_taken),
    .next_pc      (next_pc)
  );

  // State register; reset wins over every other event, including mid-WAIT.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let every flop sample pre-edge values,
    // independent of the order the always blocks are evaluated in.
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; a response is only captured while in WAIT, so
  // imem_valid in any other state (e.g. a stale reply after reset) is dropped.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ:  state_d = WAIT;
      WAIT: begin
        if (bus.imem_valid) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (accept) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // PC, held instruction and valid flag; all stable in HOLD until accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      if (capture) begin
        instr_q       <= bus.imem_rdata;
        instr_valid_q <= 1'b1;
      end
      if (accept) begin
        pc_q          <= next_pc;
        instr_valid_q <= 1'b0;
      end
    end
  end

`ifdef MIPS_FETCH_PERF_CNT_EN
  // Retired-instruction and decode-stall counters; both wrap at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_count <= '0;
      stall_count   <= '0;
    end else begin
      if (accept) begin
        retired_count <= retired_count + 32'd1;
      end
      if (instr_valid_q && !bus.decode_ready) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

  // The address bus always carries the PC, so it already equals RESET_PC
  // out of reset and is valid whenever imem_req pulses in REQ.
  assign bus.imem_req      = (state_q == REQ);
  assign bus.imem_addr     = pc_q;
  assign bus.instr         = instr_q;
  assign bus.op_code       = instr_q[OP_HI:OP_LO];
  assign bus.function_code = instr_q[FN_HI:FN_LO];
  assign bus.instr_valid   = instr_valid_q;
  assign bus.pc            = pc_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: directed test-plan steps followed
// by randomized fetches checked against a behavioural next-PC model.
// Build with MIPS_FETCH_PERF_CNT_EN defined to also check the counters.
module tb_mips_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  logic [31:0] cur_pc;

`ifdef MIPS_FETCH_PERF_CNT_EN
  logic [31:0] retired_count;
  logic [31:0] stall_count;
  logic [31:0] exp_retired;
  logic [31:0] exp_stall;
`endif

  mips_fetch_unit_if bus ();

  mips_fetch_unit #(
    .PC_WIDTH (32),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus)
`ifdef MIPS_FETCH_PERF_CNT_EN
    ,
    .retired_count (retired_count),
    .stall_count   (stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_counters(input string tag);
`ifdef MIPS_FETCH_PERF_CNT_EN
    check({tag, ":retired_count"}, retired_count, exp_retired);
    check({tag, ":stall_count"}, stall_count, exp_stall);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // Next fetch address from the architectural rules, using plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] pc_v, input logic [31:0] word,
                                             input bit j, input bit b, input bit t);
    logic [31:0] seq;
    int          off;
    seq = pc_v + 32'd4;
    if (j) return (seq & 32'hF000_0000) + (32'(word[25:0]) * 32'd4);
    if (b && t) begin
      off = int'($signed(word[15:0]));
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  // Scramble the inputs that must be ignored in the current cycle.
  task automatic scramble_controls();
    bus.is_jump      = 1'($urandom);
    bus.is_branch    = 1'($urandom);
    bus.branch_taken = 1'($urandom);
  endtask

  // Entered at a negedge in REQ with imem_addr == cur_pc. Responds after
  // 'lat' cycles, holds for 'stalls' cycles, then accepts with the given
  // controls and checks the following request address against 'nxt'.
  task automatic fetch(input string tag, input logic [31:0] word, input int lat, input int stalls,
                       input bit j, input bit b, input bit t, input logic [31:0] nxt);
    bus.imem_valid = 1'($urandom);
    bus.imem_rdata = $urandom;
    scramble_controls();
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check({tag, ":wait_req"}, 32'(bus.imem_req), 32'd0);
      check({tag, ":wait_valid"}, 32'(bus.instr_valid), 32'd0);
      scramble_controls();
      if (i == lat - 1) begin
        bus.imem_valid   = 1'b1;
        bus.imem_rdata   = word;
        bus.decode_ready = 1'b0;
      end else begin
        bus.imem_valid = 1'b0;
        bus.imem_rdata = $urandom;
      end
    end
    @(negedge clk);
    check({tag, ":instr_valid"}, 32'(bus.instr_valid), 32'd1);
    check({tag, ":instr"}, bus.instr, word);
    check({tag, ":op_code"}, 32'(bus.op_code), 32'(word[31:26]));
    check({tag, ":function_code"}, 32'(bus.function_code), 32'(word[5:0]));
    check({tag, ":pc"}, bus.pc, cur_pc);
    for (int s = 0; s < stalls; s++) begin
      bus.imem_valid   = 1'($urandom);
      bus.imem_rdata   = $urandom;
      bus.decode_ready = 1'b0;
      scramble_controls();
      @(negedge clk);
      check({tag, ":stall_instr"}, bus.instr, word);
      check({tag, ":stall_pc"}, bus.pc, cur_pc);
      check({tag, ":stall_valid"}, 32'(bus.instr_valid), 32'd1);
      check({tag, ":stall_req"}, 32'(bus.imem_req), 32'd0);
    end
    bus.imem_valid   = 1'($urandom);
    bus.imem_rdata   = $urandom;
    bus.decode_ready = 1'b1;
    bus.is_jump      = j;
    bus.is_branch    = b;
    bus.branch_taken = t;
    @(negedge clk);
    bus.decode_ready = 1'($urandom);
    scramble_controls();
    check({tag, ":next_req"}, 32'(bus.imem_req), 32'd1);
    check({tag, ":next_addr"}, bus.imem_addr, nxt);
    check({tag, ":valid_clear"}, 32'(bus.instr_valid), 32'd0);
    cur_pc = nxt;
`ifdef MIPS_FETCH_PERF_CNT_EN
    exp_retired = exp_retired + 32'd1;
    exp_stall   = exp_stall + 32'(stalls);
`endif
    check_counters(tag);
  endtask

  initial begin
    logic [31:0] word;
    logic [31:0] nxt;
    int          lat;
    int          stalls;
    bit          j;
    bit          b;
    bit          t;

    reset            = 1'b1;
    bus.imem_valid   = 1'b0;
    bus.imem_rdata   = '0;
    bus.decode_ready = 1'b0;
    bus.is_branch    = 1'b0;
    bus.branch_taken = 1'b0;
    bus.is_jump      = 1'b0;
    cur_pc           = RESET_PC;
`ifdef MIPS_FETCH_PERF_CNT_EN
    exp_retired = '0;
    exp_stall   = '0;
`endif
    repeat (3) @(negedge clk);

    // Reset state.
    check("reset:pc", bus.pc, RESET_PC);
    check("reset:instr", bus.instr, 32'd0);
    check("reset:instr_valid", 32'(bus.instr_valid), 32'd0);
    check("reset:imem_req", 32'(bus.imem_req), 32'd0);
    check("reset:imem_addr", bus.imem_addr, RESET_PC);
    check_counters("reset");

    // Release: cycle 1 IDLE, cycle 2 REQ at RESET_PC.
    reset = 1'b0;
    @(negedge clk);
    check("boot:imem_req", 32'(bus.imem_req), 32'd1);
    check("boot:imem_addr", bus.imem_addr, 32'd0);

    // Fixed-latency checks inside fetch() also pin the 3-cycle throughput.
    fetch("seq0", 32'h0000_0020, 1, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0004);
    fetch("stall5", 32'h2108_0001, 1, 5, 1'b0, 1'b0, 1'b0, 32'h0000_0008);
    fetch("j_to_40", 32'h0800_0010, 2, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0040);
    fetch("br_taken", 32'h1000_FFFE, 1, 1, 1'b0, 1'b1, 1'b1, 32'h0000_003C);
    fetch("j_back_40", 32'h0800_0010, 1, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0040);
    fetch("br_not_taken", 32'h1000_FFFE, 3, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0044);
    fetch("j_region_top", 32'h0BFF_FFFF, 1, 0, 1'b1, 1'b0, 1'b0, 32'h0FFF_FFFC);
    fetch("j_cross", 32'h0800_0000, 1, 0, 1'b1, 1'b0, 1'b0, 32'h1000_0000);
    fetch("j_and_br", 32'h0800_0100, 1, 2, 1'b1, 1'b1, 1'b1, 32'h1000_0400);

    // Reset in WAIT, then a stale response one cycle after release.
    bus.imem_valid = 1'b0;
    @(negedge clk);
    check("rst_wait:imem_req", 32'(bus.imem_req), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_wait:pc", bus.pc, RESET_PC);
    check("rst_wait:instr", bus.instr, 32'd0);
    check("rst_wait:instr_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_wait:imem_addr", bus.imem_addr, RESET_PC);
    @(negedge clk);
    reset          = 1'b0;
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.imem_valid = 1'b0;
    check("stale:imem_req", 32'(bus.imem_req), 32'd1);
    check("stale:imem_addr", bus.imem_addr, RESET_PC);
    check("stale:instr_valid", 32'(bus.instr_valid), 32'd0);
    cur_pc = RESET_PC;
`ifdef MIPS_FETCH_PERF_CNT_EN
    exp_retired = '0;
    exp_stall   = '0;
`endif
    check_counters("stale");

    // Negative branch from 0 wraps; sequential fetch from the top wraps back.
    fetch("br_wrap", 32'h1000_FFFE, 1, 0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    fetch("seq_wrap", 32'h0000_0020, 1, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);

    // Randomized fetches against the behavioural model.
    for (int n = 0; n < 30; n++) begin
      word   = $urandom;
      lat    = int'($urandom_range(1, 4));
      stalls = int'($urandom_range(0, 3));
      j      = ($urandom_range(0, 3) == 0);
      b      = 1'($urandom);
      t      = 1'($urandom);
      nxt    = model_next(cur_pc, word, j, b, t);
      fetch("rand", word, lat, stalls, j, b, t, nxt);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
- Instruction fetch sequencer that feeds the instruction decode and control logic.
- Holds the PC and issues single-outstanding requests to instruction memory.
- Presents the fetched word, with op_code and function_code fields split out, under a valid/ready handshake.
- Takes is_branch, is_jump and branch_taken back from decode and control to redirect the PC.

Parameters:
- PC_WIDTH, 32: PC and address width; must be 32.
- RESET_PC, 32'h0000_0000: PC value loaded at reset; bits [1:0] must be 0.

Ports:
- clk  in  1: single clock; all state updates on rising edge.
- reset  in  1: synchronous, active-high reset.
- imem_req  out  1: one-cycle request pulse to instruction memory.
- imem_addr  out  32: word-aligned fetch address; valid while imem_req=1.
- imem_rdata  in  32: returned instruction word.
- imem_valid  in  1: imem_rdata valid this cycle; 1 or more cycles after imem_req.
- instr  out  32: held instruction word.
- op_code  out  6: equal to instr[31:26].
- function_code  out  6: equal to instr[5:0].
- instr_valid  out  1: instr, op_code, function_code and pc are valid.
- pc  out  32: address of the held instruction.
- decode_ready  in  1: downstream accepts the instruction this cycle.
- is_branch  in  1: from control logic; held instruction is a conditional branch.
- branch_taken  in  1: branch condition true; sampled only when is_branch=1.
- is_jump  in  1: from control logic; held instruction is a jump.

Behaviour:
- Reset values: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, imem_addr=RESET_PC. Reset overrides every other event, in any state, including mid-WAIT.
- A memory response arriving after reset is discarded, because state is no longer WAIT.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: go to REQ on the next cycle.
- REQ: imem_req=1, imem_addr=pc; go to WAIT unconditionally.
- WAIT: on imem_valid=1, capture instr<=imem_rdata, set instr_valid<=1, go to HOLD. Otherwise stay in WAIT; there is no timeout.
- HOLD: instr, pc and instr_valid are stable while decode_ready=0.
- Accept = instr_valid & decode_ready. On accept: pc<=next_pc, instr_valid<=0, go to REQ.
- next_pc, computed with pc4 = pc+4, is chosen in priority order:
  - is_jump=1: next_pc = {pc4[31:28], instr[25:0], 2'b00}. A jump wins if is_jump and is_branch are both high.
  - is_branch=1 and branch_taken=1: next_pc = pc4 + (sign_extend(instr[15:0]) << 2).
  - otherwise: next_pc = pc4.
- is_branch, branch_taken and is_jump are ignored except on the accept cycle.
- Arithmetic is modulo 2^32: pc 32'hFFFF_FFFC + 4 wraps to 0, and negative branch offsets wrap the same way.
- No branch delay slot.
- imem_valid outside WAIT is ignored; no extra state is stored.
- Throughput: at most one instruction per 3 cycles (REQ, WAIT with minimum latency 1, HOLD with accept).
- With imem_valid asserted 1 cycle after imem_req and decode_ready tied high, an instruction is accepted every 3rd cycle.
- First imem_req after reset deassertion: cycle 2 (IDLE, then REQ).

Optional Feature:
- Macro: MIPS_FETCH_PERF_CNT_EN.
- When defined, two output ports are added:
  - retired_count [31:0]: +1 on every accept.
  - stall_count [31:0]: +1 on every cycle with instr_valid=1 and decode_ready=0.
- Both counters reset to 0 and wrap at 2^32.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package mips_fetch_pkg holds:
  - the state enum (IDLE, REQ, WAIT, HOLD);
  - PC_STEP=4;
  - opcode and function field bit-range constants (OP_HI=31, OP_LO=26, FN_HI=5, FN_LO=0);
  - the immediate range [15:0] and jump target range [25:0].
- One combinational sub-module, fetch_next_pc: inputs pc, instr, is_jump, is_branch, branch_taken; output next_pc.

Test Plan:
- Reset release, memory returns 32'h0000_0020 at address 0 with latency 1, decode_ready=1:
  - imem_req at cycle 2 with imem_addr=0;
  - instr_valid with op_code=0, function_code=6'h20;
  - next imem_addr=4.
- decode_ready=0 for 5 cycles while instr_valid=1:
  - instr and pc held stable, no imem_req;
  - stall_count=5 when the macro is defined.
- Taken branch at pc=32'h40, imm16=16'hFFFE, is_branch=1, branch_taken=1 → next imem_addr=32'h3C.
- Same branch with branch_taken=0 → 32'h44.
- Jump at pc=32'h1000_0000, instr[25:0]=26'h000_0100, is_jump=1 and is_branch=1 together → next imem_addr=32'h1000_0400.
- pc=32'hFFFF_FFFC, sequential accept → next imem_addr=0.
- reset asserted during WAIT, then a stale imem_valid one cycle after reset deasserts:
  - the stale response is ignored, instr_valid stays 0;
  - the fetch restarts at RESET_PC.
